// File: rtl/data_mem_port_ctrl_if.sv
// Bus bundle between the execute/memory stage, the data-port controller and
// the data port of the dual-port word memory.
//   req_*  : load/store request handshake (valid/ready) from the pipeline
//   resp_* : single-cycle completion pulse back to the pipeline
//   mem_*  : word-addressed memory port (registered, two-cycle read latency)
// Modports:
//   slave  : the controller (accepts requests, drives the memory port)
//   master : the surroundings (pipeline requester plus the memory itself)
interface data_mem_port_ctrl_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_port_ctrl.sv
// CPU-side initiator for the data port of the dual-port word memory.
// Takes one load/store at a time, does byte/half lane extraction with
// sign/zero extension on loads, and read-modify-write for sub-word stores.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : data_mem_port_ctrl_if.slave (request, response and memory port)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | req_ready=1, waiting for a request
// ISSUE   | address on memory; word store writes here, others start a read
// WAIT    | read data in flight through the memory pipeline
// CAPTURE | mem_rdata valid: extend load data or build the merged word
// MERGE   | write the merged word of a sub-word store
// RESP    | one-cycle response pulse
module data_mem_port_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  data_mem_port_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_MERGE,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t state_q, state_d;

  logic                  write_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  req_err;
  logic                  accept;
  logic [DATA_WIDTH-1:0] lane_shift;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  // Misaligned half/word or the illegal size code; detected on the request
  // itself so an erroring request never touches memory.
  assign req_err = (bus.req_size == 2'b11) ||
                   (bus.req_size == SZ_HALF && bus.req_addr[0]) ||
                   (bus.req_size == SZ_WORD && (bus.req_addr[1:0] != 2'b00));

  assign accept = (state_q == S_IDLE) && bus.req_valid;

  assign bus.mem_addr   = addr_q[ADDR_WIDTH+1:2];
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // Byte lane k moves to bits [7:0]; half lane 1 is the same shift as byte lane 2.
  assign lane_shift = bus.mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = bus.mem_rdata;
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'h000000, lane_shift[7:0]}
                                : {{24{lane_shift[7]}}, lane_shift[7:0]};
      SZ_HALF: load_ext = uns_q ? {16'h0000, lane_shift[15:0]}
                                : {{16{lane_shift[15]}}, lane_shift[15:0]};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    merged = bus.mem_rdata;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = req_err ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (write_q && size_q == SZ_WORD) begin
          bus.mem_we = 1'b1;
          state_d    = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = write_q ? S_MERGE : S_RESP;
      S_MERGE: begin
        bus.mem_we = 1'b1;
        state_d    = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rdata_q/err_q are only ever non-zero during RESP: they are loaded on the
  // edge entering RESP and cleared on the edge leaving it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= bus.req_write;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
        if (bus.req_write && bus.req_size == SZ_WORD && !req_err)
          mem_wdata_q <= bus.req_wdata;
      end
      if (state_q == S_CAPTURE) begin
        if (write_q) mem_wdata_q <= merged;
        else         rdata_q     <= load_ext;
      end
      if (state_q == S_RESP) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_port_ctrl.sv
module tb_data_mem_port_ctrl;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  data_mem_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  data_mem_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // memory model: writes commit at the edge, read data two cycles after address
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    rd_p1 <= mem[bus.mem_addr];
    rd_p2 <= rd_p1;
  end
  assign bus.mem_rdata = rd_p2;

  // reference contents as the architecture sees them
  logic [31:0] ref_mem [0:(1<<AW)-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic un,
                        input logic [AW+1:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    logic [AW-1:0] wa;
    int            lane, exp_lat, resp_cyc, we_cnt, we_cyc, quiet_bad;
    logic          exp_err, got_err;
    logic [31:0]   old, exp_rd, exp_wr, mask, v, we_data, we_addr, addr_c1;
    wa      = a[AW+1:2];
    lane    = int'(a[1:0]);
    exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    old     = ref_mem[wa];
    exp_rd  = 32'd0;
    exp_wr  = old;
    if (exp_err)          exp_lat = 1;
    else if (!wr)         exp_lat = 4;
    else if (sz == 2'd2)  exp_lat = 2;
    else                  exp_lat = 5;
    if (!exp_err && !wr) begin
      if (sz == 2'd0) begin
        v = (old >> (8 * lane)) & 32'hFF;
        if (!un && v >= 32'd128) v = v + 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
        v = (old >> (8 * lane)) & 32'hFFFF;
        if (!un && v >= 32'd32768) v = v + 32'hFFFF0000;
      end else v = old;
      exp_rd = v;
    end
    if (!exp_err && wr) begin
      if (sz == 2'd0)      mask = 32'hFF << (8 * lane);
      else if (sz == 2'd1) mask = 32'hFFFF << (8 * lane);
      else                 mask = 32'hFFFFFFFF;
      exp_wr = (old & ~mask) | ((wd << (8 * lane)) & mask);
    end

    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_unsigned = un; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    resp_cyc = 0; we_cnt = 0; we_cyc = 0; quiet_bad = 0;
    we_data = 0; we_addr = 0; addr_c1 = 0; rd = 0; got_err = 0;
    for (int c = 1; c <= 10 && resp_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) addr_c1 = 32'(bus.mem_addr);
      if (bus.mem_we) begin
        we_cnt++; we_cyc = c; we_data = bus.mem_wdata; we_addr = 32'(bus.mem_addr);
      end
      if (bus.resp_valid) begin
        resp_cyc = c; rd = bus.resp_rdata; got_err = bus.resp_err;
      end else if (bus.resp_rdata != 0 || bus.resp_err) quiet_bad++;
    end
    check_eq("resp_latency", resp_cyc, exp_lat);
    check_eq("resp_err", 32'(got_err), 32'(exp_err));
    check_eq("resp_rdata", rd, exp_rd);
    check_eq("resp_quiet", quiet_bad, 0);
    check_eq("we_count", we_cnt, (wr && !exp_err) ? 1 : 0);
    if (!exp_err) check_eq("addr_issue", addr_c1, 32'(wa));
    if (wr && !exp_err) begin
      check_eq("we_cycle", we_cyc, exp_lat - 1);
      check_eq("we_addr", we_addr, 32'(wa));
      check_eq("we_data", we_data, exp_wr);
      ref_mem[wa] = exp_wr;
    end
  endtask

  logic [31:0] rd;
  int ready_cnt, resp_cnt, overlap, bad_data, resp_seen;

  initial begin
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0;
    bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check_eq("rst_ready", 32'(bus.req_ready), 1);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 0);
    check_eq("rst_resp_err", 32'(bus.resp_err), 0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 0);

    // preload the words the test touches
    for (int w = 0; w < 16; w++)
      do_req(1'b1, 2'd2, 1'b0, 16'(w * 4), $urandom, rd);

    // directed scenarios
    do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, rd);
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, rd);
    check_eq("tp_word_load", rd, 32'hDEADBEEF);
    do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'h11223344, rd);
    do_req(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0, rd);
    check_eq("tp_byte_signed", rd, 32'h00000011);
    do_req(1'b1, 2'd0, 1'b0, 16'h0012, 32'h00000080, rd);
    do_req(1'b0, 2'd0, 1'b0, 16'h0012, 32'h0, rd);
    check_eq("tp_byte80_signed", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 16'h0012, 32'h0, rd);
    check_eq("tp_byte80_unsigned", rd, 32'h00000080);
    do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'h11223344, rd);
    do_req(1'b1, 2'd0, 1'b0, 16'h0011, 32'h000000AB, rd);
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, rd);
    check_eq("tp_rmw_byte", rd, 32'h1122AB44);
    do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'h80001234, rd);
    do_req(1'b0, 2'd1, 1'b0, 16'h0012, 32'h0, rd);
    check_eq("tp_half_signed", rd, 32'hFFFF8000);
    do_req(1'b0, 2'd1, 1'b1, 16'h0012, 32'h0, rd);
    check_eq("tp_half_unsigned", rd, 32'h00008000);
    do_req(1'b1, 2'd1, 1'b0, 16'h0012, 32'h0000BEEF, rd);
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, rd);
    check_eq("tp_rmw_half", rd, 32'hBEEF1234);

    // error requests, then confirm memory untouched
    do_req(1'b0, 2'd1, 1'b0, 16'h0001, 32'h0, rd);
    do_req(1'b1, 2'd2, 1'b0, 16'h0006, 32'hCAFEF00D, rd);
    do_req(1'b1, 2'd3, 1'b0, 16'h0008, 32'h12345678, rd);
    do_req(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0, rd);
    do_req(1'b0, 2'd2, 1'b0, 16'h0004, 32'h0, rd);
    do_req(1'b0, 2'd2, 1'b0, 16'h0008, 32'h0, rd);

    // req_valid held high: accepted only in IDLE, one load every 5 cycles
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 16'h0010;
    ready_cnt = 0; resp_cnt = 0; overlap = 0; bad_data = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.req_ready) ready_cnt++;
      if (bus.resp_valid) begin
        resp_cnt++;
        if (bus.resp_rdata != ref_mem[4]) bad_data++;
      end
      if (bus.req_ready && bus.resp_valid) overlap++;
    end
    bus.req_valid = 1'b0;
    check_eq("hold_ready_cycles", ready_cnt, 5);
    check_eq("hold_resp_count", resp_cnt, 5);
    check_eq("hold_overlap", overlap, 0);
    check_eq("hold_data", bad_data, 0);

    // reset in WAIT of a load
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
    bus.req_addr = 16'h0014;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_ready", 32'(bus.req_ready), 1);
    check_eq("midrst_resp_valid", 32'(bus.resp_valid), 0);
    check_eq("midrst_mem_addr", 32'(bus.mem_addr), 0);
    check_eq("midrst_mem_we", 32'(bus.mem_we), 0);
    @(negedge clk); rst = 1'b0;
    resp_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid) resp_seen++;
    end
    check_eq("midrst_no_resp", resp_seen, 0);
    do_req(1'b0, 2'd2, 1'b0, 16'h0014, 32'h0, rd);

    // randomized traffic over a small window so stores and loads collide
    for (int i = 0; i < 80; i++)
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             16'($urandom_range(0, 63)), $urandom, rd);
    for (int w = 0; w < 16; w++)
      do_req(1'b0, 2'd2, 1'b0, 16'(w * 4), 32'h0, rd);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
